// File: rtl/elastic_photon_pipe.sv
// Elastic, bubble-collapsing photon pipeline: PIPE_DEPTH register stages with per-stage valid,
// backpressure through an advance chain, synchronous flush and a registered occupancy count.
module elastic_photon_pipe #(
  parameter int PIPE_DEPTH = 50,
  parameter int WIDTH      = 357
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [WIDTH-1:0]                      i_photon,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [WIDTH-1:0]                      o_photon,
  input  logic                                  i_flush,
  output logic [$clog2(PIPE_DEPTH+1)-1:0]       o_count
);

  localparam int CW = $clog2(PIPE_DEPTH + 1);
  // All-zero photon with layer=1 and dead=1, shown whenever the last stage is empty.
  localparam logic [WIDTH-1:0] DEAD_PHOTON = {{(WIDTH-5){1'b0}}, 5'b00110};

  logic [PIPE_DEPTH:1] r_valid;
  logic [WIDTH-1:0]    r_data [1:PIPE_DEPTH];
  logic [CW-1:0]       r_count;

  logic [PIPE_DEPTH:1] w_adv;
  logic [PIPE_DEPTH:1] w_vprev;
  logic [WIDTH-1:0]    w_dprev [1:PIPE_DEPTH];
  logic                w_in_xfer;
  logic                w_out_xfer;

  always_comb begin
    w_vprev[1] = i_valid;
    w_dprev[1] = i_photon;
    for (int k = 2; k <= PIPE_DEPTH; k++) begin
      w_vprev[k] = r_valid[k-1];
      w_dprev[k] = r_data[k-1];
    end
  end

  // A stage may advance if it is empty or anything ahead of it can move.
  always_comb begin
    logic w_carry;
    w_carry = i_ready;
    w_adv   = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      w_carry  = !r_valid[k] | w_carry;
      w_adv[k] = w_carry;
    end
  end

  assign o_ready    = w_adv[1] & !i_flush;
  assign o_valid    = r_valid[PIPE_DEPTH];
  assign o_photon   = o_valid ? r_data[PIPE_DEPTH] : DEAD_PHOTON;
  assign o_count    = r_count;
  assign w_in_xfer  = i_valid & o_ready;
  assign w_out_xfer = o_valid & i_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        if (w_adv[k]) r_valid[k] <= w_vprev[k];
      end
      r_count <= r_count + CW'(w_in_xfer) - CW'(w_out_xfer);
    end
  end

  // Data only moves behind a valid photon, so idle inputs never reach the stages.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) r_data[k] <= DEAD_PHOTON;
    end else if (!i_flush) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        if (w_adv[k] && w_vprev[k]) r_data[k] <= w_dprev[k];
      end
    end
  end

endmodule

// File: tb/tb_elastic_photon_pipe.sv
// Bench for elastic_photon_pipe: directed scenarios plus random traffic, compared every cycle
// against a queue-of-positions model of the elastic pipe.
module tb_elastic_photon_pipe;

  localparam int D = 4;
  localparam int W = 40;
  localparam logic [W-1:0] DEAD = 40'h6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic         i_valid, i_ready, i_flush, o_valid, o_ready;
  logic [W-1:0] i_photon, o_photon;
  logic [2:0]   o_count;

  logic         v1, rdy1, fl1, ov1, ord1;
  logic [W-1:0] d1, op1, d1_sent;
  logic         oc1;

  elastic_photon_pipe #(.PIPE_DEPTH(D), .WIDTH(W)) u_dut (
    .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_photon(i_photon), .o_valid(o_valid), .i_ready(i_ready),
    .o_photon(o_photon), .i_flush(i_flush), .o_count(o_count));

  elastic_photon_pipe #(.PIPE_DEPTH(1), .WIDTH(W)) u_dut1 (
    .clock(clock), .reset(reset), .i_valid(v1), .o_ready(ord1),
    .i_photon(d1), .o_valid(ov1), .i_ready(rdy1),
    .o_photon(op1), .i_flush(fl1), .o_count(oc1));

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 1;

  // Model: photons in flight, oldest first, each with its stage position 1..D.
  int           m_pos[$];
  logic [W-1:0] m_dat[$];
  int           np_q[$];
  bit           pl_pop, pl_rdy;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int x);
    logic [31:0] xv;
    logic [7:0]  lo;
    xv = x;
    lo = 8'($urandom);
    return {xv, lo};
  endfunction

  // Each photon moves one stage unless it would collide with the (already moved) photon ahead.
  function automatic void model_plan(input bit rdy);
    int lim;
    int n;
    np_q.delete();
    pl_pop = (m_pos.size() > 0) && (m_pos[0] == D) && rdy;
    lim = D + 1;
    foreach (m_pos[i]) begin
      if (i == 0 && pl_pop) continue;
      n = m_pos[i] + 1;
      if (n > lim - 1) n = lim - 1;
      np_q.push_back(n);
      lim = n;
    end
    pl_rdy = (np_q.size() == 0) || (np_q[np_q.size()-1] > 1);
  endfunction

  task automatic model_clear();
    m_pos.delete();
    m_dat.delete();
  endtask

  task automatic cycle(input bit v, input bit rdy, input bit fl);
    logic [W-1:0] d;
    logic [W-1:0] exp_ph;
    bit           exp_rdy, exp_vld;
    @(negedge clock);
    d = mk(seq);
    i_valid = v; i_photon = d; i_ready = rdy; i_flush = fl;
    model_plan(rdy);
    exp_rdy = pl_rdy && !fl;
    exp_vld = (m_pos.size() > 0) && (m_pos[0] == D);
    exp_ph  = exp_vld ? m_dat[0] : DEAD;
    #1;
    check_val("o_valid", o_valid, exp_vld);
    check_val("o_photon", o_photon, exp_ph);
    check_val("o_ready", o_ready, exp_rdy);
    check_val("o_count", o_count, m_pos.size());
    if (fl) begin
      model_clear();
    end else begin
      if (pl_pop) void'(m_dat.pop_front());
      m_pos = np_q;
      if (v && exp_rdy) begin
        m_pos.push_back(1);
        m_dat.push_back(d);
        seq++;
      end
    end
    @(posedge clock);
  endtask

  initial begin
    reset = 1'b0;
    i_valid = 0; i_ready = 1; i_flush = 0; i_photon = '0;
    v1 = 0; rdy1 = 1; fl1 = 0; d1 = '0;
    #2;
    check_val("rst_o_valid", o_valid, 0);
    check_val("rst_o_count", o_count, 0);
    check_val("rst_o_ready", o_ready, 1);
    check_val("rst_o_photon", o_photon, DEAD);
    check_val("rst_d1_o_valid", ov1, 0);
    @(negedge clock);
    reset = 1'b1;

    // Back-to-back stream with no stall: first output after exactly D edges.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, 0);
      if (i == D - 1) begin
        #1;
        check_val("lat_o_valid", o_valid, 1);
        check_val("lat_first_x", o_photon[W-1:8], 1);
      end
    end
    for (int i = 0; i < D + 1; i++) cycle(0, 1, 0);

    // Stalled stream of 6: pipe fills to 4 and holds the oldest photon.
    seq = 1;
    for (int i = 0; i < 6; i++) cycle(1, 0, 0);
    #1;
    check_val("stall_count", o_count, 4);
    check_val("stall_ready", o_ready, 0);
    check_val("stall_head_x", o_photon[W-1:8], 1);
    for (int i = 0; i < 10; i++) cycle(i < 2, 1, 0);
    check_val("drain_count", o_count, 0);

    // Gapped arrivals while stalled collapse into a full pipe.
    cycle(1, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0);
    cycle(0, 0, 0); cycle(1, 0, 0); cycle(0, 0, 0); cycle(1, 0, 0);
    #1;
    check_val("collapse_count", o_count, 4);
    check_val("collapse_ready", o_ready, 0);

    // Full pipe streaming: one in, one out, count constant.
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0);
      #1;
      check_val("full_stream_count", o_count, 4);
    end

    // Flush with an offered input.
    cycle(1, 1, 1);
    #1;
    check_val("flush_o_valid", o_valid, 0);
    check_val("flush_o_count", o_count, 0);
    check_val("flush_o_photon", o_photon, DEAD);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);

    // Asynchronous reset between edges while photons are in flight.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    @(negedge clock);
    i_valid = 0; i_ready = 0;
    #2 reset = 1'b0;
    #1;
    check_val("async_rst_o_valid", o_valid, 0);
    check_val("async_rst_o_count", o_count, 0);
    check_val("async_rst_o_photon", o_photon, DEAD);
    check_val("async_rst_o_ready", o_ready, 1);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1, 1, 0);

    // Single-stage pipe: one-cycle latency.
    @(negedge clock);
    d1_sent = mk(77);
    v1 = 1; d1 = d1_sent;
    #1;
    check_val("d1_o_ready", ord1, 1);
    @(posedge clock);
    #1;
    check_val("d1_o_valid", ov1, 1);
    check_val("d1_o_photon", op1, d1_sent);
    check_val("d1_o_count", oc1, 1);
    @(negedge clock);
    v1 = 0;
    @(posedge clock);
    #1;
    check_val("d1_empty_valid", ov1, 0);
    check_val("d1_empty_photon", op1, DEAD);
    check_val("d1_empty_count", oc1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_photon_pipe.md
ELASTIC_PHOTON_PIPE -- requirements
Module: elastic_photon_pipe

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 50, number of register stages (legal 1..64).
REQ-002 SHALL have parameter WIDTH, default 357, packed photon bus width (legal >= 5).
REQ-003 SHALL have port clock  in  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_valid  in  1  upstream photon present.
REQ-006 SHALL have port o_ready  out  1  pipe accepts i_photon this cycle.
REQ-007 SHALL have port i_photon  in  WIDTH  packed photon {x,y,z,ux,uy,uz,sz,sr,sleftz,sleftr,weight,layer,dead,hit}: hit bit 0, dead bit 1, layer bits 4:2, 32-bit fields above.
REQ-008 SHALL have port o_valid  out  1  photon present at last stage.
REQ-009 SHALL have port i_ready  in  1  downstream accepts o_photon.
REQ-010 SHALL have port o_photon  out  WIDTH  photon at last stage.
REQ-011 SHALL have port i_flush  in  1  synchronous discard of all contents.
REQ-012 SHALL have port o_count  out  clog2(PIPE_DEPTH+1)  number of valid stages.

Function
REQ-013 SHALL hold per stage k (1..PIPE_DEPTH) a WIDTH-bit data register and a valid bit; stage 0 denotes the inputs (i_valid, i_photon).
REQ-014 SHALL compute advance[PIPE_DEPTH] = !valid[PIPE_DEPTH] | i_ready, and advance[k] = !valid[k] | advance[k+1] for k < PIPE_DEPTH (bubble collapsing: a stage fills whenever it is empty, regardless of stalls downstream).
REQ-015 SHALL, when advance[k], load valid[k] <= valid[k-1] and, only if valid[k-1], data[k] <= data[k-1]; otherwise hold both.
REQ-016 SHALL drive o_ready = advance[1] & !i_flush; input transfer when i_valid & o_ready; output transfer when o_valid & i_ready.
REQ-017 SHALL give latency of exactly PIPE_DEPTH cycles from input transfer to o_valid when never stalled; throughput one photon per cycle.
REQ-018 SHALL keep photon order; no photon duplicated or dropped except by flush or reset.
REQ-019 SHALL drive o_valid = valid[PIPE_DEPTH]; o_photon = data[PIPE_DEPTH] when o_valid, else the dead-photon pattern (all zero, layer=3'b001, dead=1, hit=0).
REQ-020 SHALL hold o_photon stable while o_valid & !i_ready.
REQ-021 SHALL, on i_flush, clear all valid bits at the next edge, leave data registers unchanged, ignore i_valid that cycle, and set o_count to 0; flush beats simultaneous input/output transfers (output transfer in the flush cycle still counts as consumed by downstream).
REQ-022 SHALL update o_count registered: count + in_xfer - out_xfer, saturating never needed (bounded 0..PIPE_DEPTH); o_count always equals popcount of valid bits.
REQ-023 SHALL allow simultaneous input and output transfer when full (i_ready high propagates through advance chain), count unchanged.
REQ-024 SHALL leave i_ready/i_valid ignored with respect to data path when no transfer occurs (no X propagation from idle data).

Reset
REQ-025 SHALL, while reset low, asynchronously clear all valid bits, set all data registers to the dead-photon pattern, and set o_count=0.
REQ-026 SHALL present o_valid=0, o_photon=dead pattern, o_ready=1 (unless i_flush) immediately during reset; reset mid-stream discards all photons.
REQ-027 SHALL deassert reset synchronously to clock in system use; first transfer allowed on the first edge after release.

Verification
REQ-028 PIPE_DEPTH=4, i_ready=1, 10 back-to-back photons x=1..10 -> o_valid first after 4 cycles, x=1..10 in order consecutive cycles, o_count peaks 4.
REQ-029 PIPE_DEPTH=4, i_ready=0, stream 6 photons -> o_ready low after 4 accepted, o_count=4, o_photon holds x=1; raise i_ready -> x=1..6 delivered, count returns 0.
REQ-030 PIPE_DEPTH=4, single photon then i_ready=0, then 3 more with gaps -> stages collapse, o_count=4 after 4 transfers, no bubble remains.
REQ-031 Full pipe, i_valid=1 and i_ready=1 -> one in, one out per cycle, o_count constant 4.
REQ-032 Full pipe, pulse i_flush with i_valid=1 -> o_ready=0 that cycle, next cycle o_valid=0, o_count=0, o_photon=dead pattern (bit1=1, bits4:2=001).
REQ-033 Assert reset low asynchronously mid-stream between edges -> o_valid=0 and o_count=0 before next edge; after release, PIPE_DEPTH=1 gives 1-cycle latency.
